// File: rtl/wb_commit_arb_pkg.sv
// Shared constants and types for the writeback commit arbiter.
// Register/commit-ID widths and execution-unit source indices live here.
package wb_commit_arb_pkg;

    localparam int REG_ADDR_WIDTH  = 5;
    localparam int COMMIT_ID_WIDTH = 3;

    localparam int SRC_ALU = 0;
    localparam int SRC_MUL = 1;
    localparam int SRC_DIV = 2;
    localparam int SRC_LSU = 3;

    // Per-source holding-register metadata; the data word is kept separately
    // because its width is a module parameter.
    typedef struct packed {
        logic                       we;
        logic [REG_ADDR_WIDTH-1:0]  rd;
        logic [COMMIT_ID_WIDTH-1:0] id;
    } hold_meta_t;

endpackage

// File: rtl/wb_commit_arb_rr_pick2.sv
// Two-grant round-robin picker: finds the first and second set request bits
// scanning upward from ptr with wrap-around.
module rr_pick2
    import wb_commit_arb_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int IDX_WIDTH = 2
) (
    input  logic [NUM_REQ-1:0]   req,
    input  logic [IDX_WIDTH-1:0] ptr,
    output logic [IDX_WIDTH-1:0] grant_a,
    output logic                 grant_a_valid,
    output logic [IDX_WIDTH-1:0] grant_b,
    output logic                 grant_b_valid
);

    always_comb begin
        int idx;
        idx           = 0;
        grant_a       = '0;
        grant_a_valid = 1'b0;
        grant_b       = '0;
        grant_b_valid = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (req[idx]) begin
                if (!grant_a_valid) begin
                    grant_a_valid = 1'b1;
                    grant_a       = IDX_WIDTH'(idx);
                end else if (!grant_b_valid) begin
                    grant_b_valid = 1'b1;
                    grant_b       = IDX_WIDTH'(idx);
                end
            end
        end
    end

endmodule

// File: rtl/wb_commit_arb.sv
// Writeback commit arbiter: one holding register per execution unit, up to two
// commits per cycle onto a dual-write-port register file, round-robin fair.
module wb_commit_arb
    import wb_commit_arb_pkg::*;
#(
    parameter int NUM_SRC    = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [NUM_SRC-1:0]                 src_valid_i,
    output logic [NUM_SRC-1:0]                 src_ready_o,
    input  logic [NUM_SRC*COMMIT_ID_WIDTH-1:0] src_commit_id_i,
    input  logic [NUM_SRC*REG_ADDR_WIDTH-1:0]  src_rd_addr_i,
    input  logic [NUM_SRC-1:0]                 src_rd_we_i,
    input  logic [NUM_SRC*DATA_WIDTH-1:0]      src_rd_data_i,
    output logic                               reg_we_o,
    output logic [REG_ADDR_WIDTH-1:0]          reg_waddr_o,
    output logic [DATA_WIDTH-1:0]              reg_wdata_o,
    output logic                               reg_we2_o,
    output logic [REG_ADDR_WIDTH-1:0]          reg_waddr2_o,
    output logic [DATA_WIDTH-1:0]              reg_wdata2_o,
    output logic                               commit_valid_o,
    output logic [COMMIT_ID_WIDTH-1:0]         commit_id_o,
    output logic                               commit_valid2_o,
    output logic [COMMIT_ID_WIDTH-1:0]         commit_id2_o
);

    localparam int PW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    logic [NUM_SRC-1:0]    hold_valid;
    hold_meta_t            hold_meta [NUM_SRC];
    logic [DATA_WIDTH-1:0] hold_data [NUM_SRC];
    logic [PW-1:0]         rr_ptr;

    logic [PW-1:0]         grant_a;
    logic [PW-1:0]         grant_b;
    logic                  grant_a_valid;
    logic                  grant_b_valid;
    logic                  grant_b_ok;
    logic                  waw_conflict;
    hold_meta_t            meta_a;
    hold_meta_t            meta_b;
    logic [NUM_SRC-1:0]    grant;

    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] idx);
        return (int'(idx) == NUM_SRC - 1) ? '0 : idx + 1'b1;
    endfunction

    rr_pick2 #(
        .NUM_REQ   (NUM_SRC),
        .IDX_WIDTH (PW)
    ) u_pick (
        .req           (hold_valid),
        .ptr           (rr_ptr),
        .grant_a       (grant_a),
        .grant_a_valid (grant_a_valid),
        .grant_b       (grant_b),
        .grant_b_valid (grant_b_valid)
    );

    assign meta_a = hold_meta[grant_a];
    assign meta_b = hold_meta[grant_b];

    // Two writes to the same architectural register in one cycle: B waits.
    assign waw_conflict = meta_a.we & meta_b.we & (meta_a.rd == meta_b.rd)
                        & (meta_a.rd != '0);
    assign grant_b_ok   = grant_b_valid & ~waw_conflict;

    always_comb begin
        grant = '0;
        if (grant_a_valid) grant[grant_a] = 1'b1;
        if (grant_b_ok)    grant[grant_b] = 1'b1;
    end

    assign src_ready_o = ~hold_valid | grant;

    always_comb begin
        reg_we_o        = 1'b0;
        reg_waddr_o     = '0;
        reg_wdata_o     = '0;
        commit_valid_o  = 1'b0;
        commit_id_o     = '0;
        reg_we2_o       = 1'b0;
        reg_waddr2_o    = '0;
        reg_wdata2_o    = '0;
        commit_valid2_o = 1'b0;
        commit_id2_o    = '0;
        if (grant_a_valid) begin
            reg_we_o       = meta_a.we & (meta_a.rd != '0);
            reg_waddr_o    = meta_a.rd;
            reg_wdata_o    = hold_data[grant_a];
            commit_valid_o = (meta_a.id != '0);
            commit_id_o    = meta_a.id;
        end
        if (grant_b_ok) begin
            reg_we2_o       = meta_b.we & (meta_b.rd != '0);
            reg_waddr2_o    = meta_b.rd;
            reg_wdata2_o    = hold_data[grant_b];
            commit_valid2_o = (meta_b.id != '0);
            commit_id2_o    = meta_b.id;
        end
    end

    // A new accept overrides the clear of a just-granted entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_valid <= '0;
            for (int i = 0; i < NUM_SRC; i++) begin
                hold_meta[i] <= '0;
                hold_data[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (src_valid_i[i] && src_ready_o[i]) begin
                    hold_valid[i]   <= 1'b1;
                    hold_meta[i].we <= src_rd_we_i[i];
                    hold_meta[i].rd <= src_rd_addr_i[i*REG_ADDR_WIDTH +: REG_ADDR_WIDTH];
                    hold_meta[i].id <= src_commit_id_i[i*COMMIT_ID_WIDTH +: COMMIT_ID_WIDTH];
                    hold_data[i]    <= src_rd_data_i[i*DATA_WIDTH +: DATA_WIDTH];
                end else if (grant[i]) begin
                    hold_valid[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (grant_b_ok) begin
            rr_ptr <= wrap_inc(grant_b);
        end else if (grant_a_valid) begin
            rr_ptr <= wrap_inc(grant_a);
        end
    end

endmodule
